avg_window_sequencer: RTL and testbench

- Frame-level controller for the 3x3 RGB444 averaging filter.
- Walks the source image in raster order and fetches the 9 neighbourhood pixels of each output pixel from the source pixel RAM, clamping coordinates at the borders.
- Packs the pixels into the filter's 108-bit window bus and strobes window_valid.
- Issues the destination-RAM write address and enable, delayed to line up with the filter's registered output.

---
 rtl/avg_window_sequencer_pkg.sv | 42 ++++
 rtl/avg_wb_delay.sv | 50 +++++
 rtl/avg_window_sequencer.sv | 176 +++++++++++++++++
 tb/tb_avg_window_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/avg_window_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avg_window_sequencer_pkg
//  Description : Shared constants, tap slot indices and FSM encoding for the
//                3x3 RGB444 averaging-filter window sequencer.
//                Tap slot k occupies window bits [tap_lsb(k)+11 : tap_lsb(k)],
//                i.e. bit offset 96-12k, so the centre pixel sits in the MSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
package avg_window_sequencer_pkg;

    localparam int PIX_W  = 12;
    localparam int WIN_W  = 108;
    localparam int N_TAPS = 9;

    // Fetch order of the neighbourhood; also the slot index in the window.
    localparam logic [3:0] TAP_CENTER    = 4'd0;
    localparam logic [3:0] TAP_LEFT      = 4'd1;
    localparam logic [3:0] TAP_RIGHT     = 4'd2;
    localparam logic [3:0] TAP_UP        = 4'd3;
    localparam logic [3:0] TAP_DOWN      = 4'd4;
    localparam logic [3:0] TAP_UPLEFT    = 4'd5;
    localparam logic [3:0] TAP_UPRIGHT   = 4'd6;
    localparam logic [3:0] TAP_DOWNLEFT  = 4'd7;
    localparam logic [3:0] TAP_DOWNRIGHT = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // LSB position of tap slot k inside the packed window.
    function automatic int tap_lsb(input logic [3:0] k);
        return (N_TAPS - 1 - int'(k)) * PIX_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avg_wb_delay.sv
`default_nettype none
// ============================================================================
//  Module      : avg_wb_delay
//  Description : DEPTH-stage shift register carrying {valid, addr} from the
//                window strobe to the destination write port. Cleared by the
//                synchronous reset.
//  Ports       : clk, reset        - clock / synchronous active-high reset
//                i_valid, i_addr   - entry pushed every cycle
//                o_valid, o_addr   - last stage (write enable / address)
//                o_any             - some stage still holds a valid entry
//  Revision    : 1.0 - initial release
// ============================================================================
module avg_wb_delay #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_any
);

    logic [DEPTH-1:0] r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_addr  = r_addr[DEPTH-1];
    assign o_any   = |r_valid;

endmodule
`default_nettype wire

// File: rtl/avg_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : avg_window_sequencer
//  Description : Frame controller for the 3x3 averaging filter. Walks the
//                image in raster order, reads the 9 clamped neighbours of each
//                pixel (11 cycles per pixel), packs them into the 108-bit
//                window and issues the delayed destination write.
//  Ports       : clk, reset              - clock / sync active-high reset
//                start                   - frame start pulse (IDLE only)
//                busy, done              - status / end-of-frame pulse
//                src_rd_en, src_addr     - source RAM read port
//                src_data                - source pixel, 1 cycle after read
//                window_data/valid       - packed window to the filter
//                dst_we, dst_addr        - destination RAM write port
//  Revision    : 1.0 - initial release
// ============================================================================
module avg_window_sequencer
    import avg_window_sequencer_pkg::*;
#(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int ADDR_W     = 15,
    parameter int FILTER_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic [WIN_W-1:0]  window_data,
    output logic              window_valid,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr
);

    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [X_W-1:0]    c_X_MAX    = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    c_Y_MAX    = Y_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(IMG_W);

    state_t            r_state, w_next_state;
    logic [3:0]        r_k;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_row;           // y*IMG_W, kept incrementally
    logic              r_cap_en;        // src_data this cycle belongs to r_cap_k
    logic [3:0]        r_cap_k;
    logic [WIN_W-1:0]  r_stage;         // window being assembled
    logic [WIN_W-1:0]  r_window;        // window presented to the filter

    logic              w_fetch, w_emit, w_last, w_any;
    logic [X_W-1:0]    w_x_lo, w_x_hi, w_tap_col;
    logic [ADDR_W-1:0] w_row_up, w_row_dn, w_tap_row, w_tap_addr;

    assign w_fetch = (r_state == ST_FETCH);
    assign w_emit  = (r_state == ST_EMIT);
    assign w_last  = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_FETCH;
            ST_FETCH: if (r_k == TAP_DOWNRIGHT) w_next_state = ST_DRAIN;
            ST_DRAIN: w_next_state = ST_EMIT;
            ST_EMIT:  w_next_state = w_last ? ST_FLUSH : ST_FETCH;
            ST_FLUSH: if (!w_any) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------- raster / tap counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k   <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_row <= '0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_k   <= '0;
                r_x   <= '0;
                r_y   <= '0;
                r_row <= '0;
            end
        end else if (w_fetch) begin
            r_k <= (r_k == TAP_DOWNRIGHT) ? 4'd0 : r_k + 4'd1;
        end else if (w_emit) begin
            if (r_x == c_X_MAX) begin
                r_x   <= '0;
                r_y   <= r_y + 1'b1;
                r_row <= r_row + c_ROW_STEP;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // --------------------------------------------- clamped tap addressing
    always_comb begin
        w_x_lo    = (r_x == '0)      ? r_x   : r_x - 1'b1;
        w_x_hi    = (r_x == c_X_MAX) ? r_x   : r_x + 1'b1;
        w_row_up  = (r_y == '0)      ? r_row : r_row - c_ROW_STEP;
        w_row_dn  = (r_y == c_Y_MAX) ? r_row : r_row + c_ROW_STEP;
        w_tap_col = r_x;
        w_tap_row = r_row;
        case (r_k)
            TAP_LEFT:      w_tap_col = w_x_lo;
            TAP_RIGHT:     w_tap_col = w_x_hi;
            TAP_UP:        w_tap_row = w_row_up;
            TAP_DOWN:      w_tap_row = w_row_dn;
            TAP_UPLEFT:    begin w_tap_row = w_row_up; w_tap_col = w_x_lo; end
            TAP_UPRIGHT:   begin w_tap_row = w_row_up; w_tap_col = w_x_hi; end
            TAP_DOWNLEFT:  begin w_tap_row = w_row_dn; w_tap_col = w_x_lo; end
            TAP_DOWNRIGHT: begin w_tap_row = w_row_dn; w_tap_col = w_x_hi; end
            default:       ;
        endcase
        w_tap_addr = w_tap_row + ADDR_W'(w_tap_col);
    end

    // ------------------------------------------------------ window capture
    // Taps 0..7 land in the staging register; tap 8 arrives in DRAIN and is
    // merged straight into the output copy so window_data only changes once
    // per pixel, right as EMIT begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_en <= 1'b0;
            r_cap_k  <= '0;
            r_stage  <= '0;
            r_window <= '0;
        end else begin
            r_cap_en <= w_fetch;
            r_cap_k  <= r_k;
            if (r_cap_en) begin
                if (r_cap_k == TAP_DOWNRIGHT) begin
                    r_window <= {r_stage[WIN_W-1:PIX_W], src_data};
                end else begin
                    r_stage[tap_lsb(r_cap_k) +: PIX_W] <= src_data;
                end
            end
        end
    end

    // ---------------------------------------------- write-back delay line
    avg_wb_delay #(
        .DEPTH  (FILTER_LAT),
        .ADDR_W (ADDR_W)
    ) u_wb_delay (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_emit),
        .i_addr  (r_row + ADDR_W'(r_x)),
        .o_valid (dst_we),
        .o_addr  (dst_addr),
        .o_any   (w_any)
    );

    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign src_rd_en    = w_fetch;
    assign src_addr     = w_fetch ? w_tap_addr : '0;
    assign window_valid = w_emit;
    assign window_data  = r_window;

endmodule
`default_nettype wire

// File: tb/tb_avg_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avg_window_sequencer
//  Description : Self-checking bench for avg_window_sequencer on a 4x3 image.
//                Expected source addresses, windows, write addresses and write
//                timing are queued per frame and checked as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avg_window_sequencer;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int ADDR_W = 4;
    localparam int LAT = 4;
    localparam int NPIX = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, src_rd_en, window_valid, dst_we;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [11:0]   src_data;
    logic [107:0]  window_data;

    avg_window_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FILTER_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .window_data(window_data), .window_valid(window_valid),
        .dst_we(dst_we), .dst_addr(dst_addr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Source RAM, RAM[a] = a, data visible the cycle after the read.
    logic          pend_rd = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    initial src_data = '0;
    always @(negedge clk) begin
        src_data  = pend_rd ? {8'd0, pend_addr} : 12'd0;
        pend_rd   = src_rd_en;
        pend_addr = src_addr;
    end

    // Scoreboard queues
    logic [ADDR_W-1:0] exp_src[$];
    logic [107:0]      exp_win[$];
    logic [ADDR_W-1:0] exp_dst[$];
    int                exp_we_cyc[$];
    int rd_rise[$], rd_fall[$], wv_cyc[$], we_cyc[$];
    int n_wv = 0, n_we = 0, n_done = 0, done_cyc = 0, last_we_cyc = 0;
    logic prev_rd = 1'b0;

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic push_frame();
        int xs[9], ys[9], a;
        logic [107:0] w;
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                xs = '{x, x-1, x+1, x, x, x-1, x+1, x-1, x+1};
                ys = '{y, y, y, y-1, y+1, y-1, y-1, y+1, y+1};
                w = '0;
                for (int k = 0; k < 9; k++) begin
                    a = clampi(ys[k], IMG_H-1) * IMG_W + clampi(xs[k], IMG_W-1);
                    exp_src.push_back(ADDR_W'(a));
                    w[107-12*k -: 12] = 12'(a);
                end
                exp_win.push_back(w);
                exp_dst.push_back(ADDR_W'(y*IMG_W + x));
            end
        end
    endtask

    task automatic clear_sb();
        exp_src.delete(); exp_win.delete(); exp_dst.delete(); exp_we_cyc.delete();
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_rd = 1'b0;
        end else begin
            if (src_rd_en) begin
                check_val("src_q", exp_src.size() != 0, 1);
                if (exp_src.size() != 0) check_val("src_addr", src_addr, exp_src.pop_front());
            end
            if (src_rd_en && !prev_rd) rd_rise.push_back(cyc);
            if (!src_rd_en && prev_rd) rd_fall.push_back(cyc);
            prev_rd = src_rd_en;
            if (window_valid) begin
                n_wv++;
                wv_cyc.push_back(cyc);
                exp_we_cyc.push_back(cyc + LAT);
                check_val("win_q", exp_win.size() != 0, 1);
                if (exp_win.size() != 0) check_val("window", window_data, exp_win.pop_front());
            end
            if (dst_we) begin
                n_we++;
                last_we_cyc = cyc;
                we_cyc.push_back(cyc);
                check_val("dst_q", exp_dst.size() != 0, 1);
                if (exp_dst.size() != 0) check_val("dst_addr", dst_addr, exp_dst.pop_front());
                if (exp_we_cyc.size() != 0) check_val("we_latency", cyc, exp_we_cyc.pop_front());
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check_val("busy_in_done", busy, 1);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_rd_en"}, src_rd_en, 0);
        check_val({tag, "_src_addr"}, src_addr, 0);
        check_val({tag, "_win"}, window_data, 0);
        check_val({tag, "_wv"}, window_valid, 0);
        check_val({tag, "_we"}, dst_we, 0);
        check_val({tag, "_dst_addr"}, dst_addr, 0);
    endtask

    task automatic run_frame(input bit mid_start, input bit timing);
        int t0, wv0, we0, d0, guard;
        wv0 = n_wv; we0 = n_we; d0 = n_done;
        rd_rise.delete(); rd_fall.delete(); wv_cyc.delete(); we_cyc.delete();
        push_frame();
        start = 1'b1; t0 = cyc; tick(); start = 1'b0;
        if (mid_start) begin
            repeat (30) tick();
            start = 1'b1; tick(); start = 1'b0;
        end
        guard = 0;
        while (n_done == d0 && guard < 400) begin tick(); guard++; end
        check_val("done_seen", n_done - d0, 1);
        tick();
        check_val("busy_after_done", busy, 0);
        repeat (5) tick();
        check_val("frame_wv", n_wv - wv0, NPIX);
        check_val("frame_we", n_we - we0, NPIX);
        check_val("frame_done_cnt", n_done - d0, 1);
        check_val("src_left", exp_src.size(), 0);
        check_val("win_left", exp_win.size(), 0);
        check_val("dst_left", exp_dst.size(), 0);
        check_val("done_after_last_we", done_cyc - last_we_cyc, 2);
        if (timing) begin
            check_val("rd_rise_cnt", rd_rise.size() >= 2, 1);
            check_val("wv_cnt", wv_cyc.size() >= 1, 1);
            check_val("we_cnt", we_cyc.size() >= 1, 1);
            if (rd_rise.size() >= 2) begin
                check_val("rd_first", rd_rise[0] - t0, 1);
                check_val("rd_second", rd_rise[1] - t0, 12);
            end
            if (rd_fall.size() >= 1) check_val("rd_fall", rd_fall[0] - t0, 10);
            if (wv_cyc.size() >= 1) check_val("wv_first", wv_cyc[0] - t0, 11);
            if (we_cyc.size() >= 1) check_val("we_first", we_cyc[0] - t0, 15);
        end
    endtask

    initial begin
        int guard, snap_we, snap_done, snap_wv, wv0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check_idle_outputs("rst");
        start = 1'b1; tick(); start = 1'b0;
        check_val("start_in_reset_busy", busy, 0);
        reset = 1'b0;
        tick();
        check_val("post_reset_busy", busy, 0);
        check_val("post_reset_rd", src_rd_en, 0);

        // Frame 1: timing, full scoreboard, ignored mid-frame start
        run_frame(1'b1, 1'b1);

        // Frame 2: abort with reset during the sixth pixel's fetch
        wv0 = n_wv;
        push_frame();
        start = 1'b1; tick(); start = 1'b0;
        guard = 0;
        while (n_wv - wv0 < 5 && guard < 200) begin tick(); guard++; end
        check_val("reached_pixel5", n_wv - wv0, 5);
        guard = 0;
        while (!src_rd_en && guard < 20) begin tick(); guard++; end
        check_val("pixel5_fetch", src_rd_en, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("abort");
        clear_sb();
        snap_we = n_we; snap_done = n_done; snap_wv = n_wv;
        reset = 1'b0;
        repeat (60) tick();
        check_val("abort_no_we", n_we - snap_we, 0);
        check_val("abort_no_done", n_done - snap_done, 0);
        check_val("abort_no_wv", n_wv - snap_wv, 0);
        check_val("abort_idle", busy, 0);

        // Frame 3: clean run after the abort
        run_frame(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
